// File: rtl/regfile_write_scheduler_if.sv
// Bundle of the producer handshakes, issue port, read-address mirrors and
// register-file write port shared by the write scheduler and its neighbours.
interface regfile_write_scheduler_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  read_address_1;
  logic [4:0]  read_address_2;
  logic        hazard_1;
  logic        hazard_2;
  logic [4:0]  write_address;
  logic [31:0] write_value;

  // Pipeline side: drives producer results, issue requests and read addresses
  modport master (
    output alu_valid, alu_rd, alu_value,
    output mem_valid, mem_rd, mem_value,
    output issue_valid, issue_rd,
    output read_address_1, read_address_2,
    input  alu_ready, mem_ready, issue_ready,
    input  hazard_1, hazard_2,
    input  write_address, write_value
  );

  // Scheduler side
  modport slave (
    input  alu_valid, alu_rd, alu_value,
    input  mem_valid, mem_rd, mem_value,
    input  issue_valid, issue_rd,
    input  read_address_1, read_address_2,
    output alu_ready, mem_ready, issue_ready,
    output hazard_1, hazard_2,
    output write_address, write_value
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between the ALU result path
// (default priority) and the memory/long-latency return path (protected by an
// anti-starvation counter), and keeps a pending-write scoreboard that flags
// RAW hazards on both read ports and blocks WAW issues.
module regfile_write_scheduler #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  regfile_write_scheduler_if.slave bus
);

  typedef enum logic [0:0] {ST_NORMAL, ST_FORCE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:1] pending_q, pending_d;

  logic [31:0] pend_full;
  logic        alu_grant, mem_grant;
  logic        mem_hs, mem_clear, issue_ok, issue_set;
  logic [4:0]  wr_addr;
  logic [31:0] wr_value;

  // Bit 0 is the hardwired zero register and never pending
  assign pend_full = {pending_q, 1'b0};

  // Grant selection, wait counter and FSM next state
  always_comb begin
    alu_grant  = 1'b0;
    mem_grant  = 1'b0;
    wr_addr    = 5'd0;
    wr_value   = 32'd0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    // A forced state without a mem request falls through to normal priority
    if (state_q == ST_FORCE && bus.mem_valid) begin
      mem_grant = 1'b1;
    end else if (bus.alu_valid) begin
      alu_grant = 1'b1;
    end else if (bus.mem_valid) begin
      mem_grant = 1'b1;
    end

    if (alu_grant) begin
      wr_addr  = bus.alu_rd;
      wr_value = bus.alu_value;
    end else if (mem_grant) begin
      wr_addr  = bus.mem_rd;
      wr_value = bus.mem_value;
    end

    if (bus.mem_valid && mem_grant) begin
      wait_cnt_d = 4'd0;
      state_d    = ST_NORMAL;
    end else if (bus.mem_valid) begin
      if (wait_cnt_q == 4'(MAX_WAIT - 1)) begin
        wait_cnt_d = 4'd0;
        state_d    = ST_FORCE;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end else begin
      state_d = ST_NORMAL;
    end
  end

  assign mem_hs    = bus.mem_valid && mem_grant;
  assign mem_clear = mem_hs && (bus.mem_rd != 5'd0);
  // A write retiring this cycle to the same rd frees the slot for the new issue
  assign issue_ok  = (bus.issue_rd == 5'd0) || !pend_full[bus.issue_rd] ||
                     (mem_hs && (bus.mem_rd == bus.issue_rd));
  assign issue_set = bus.issue_valid && issue_ok && !reset;

  // Per-register scoreboard update; set is applied after clear so it wins
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      assign pending_d[gi] = (issue_set && (bus.issue_rd == 5'(gi))) ||
                             (pending_q[gi] && !(mem_clear && (bus.mem_rd == 5'(gi))));
    end
  endgenerate

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    bus.alu_ready     = 1'b0;
    bus.mem_ready     = 1'b0;
    bus.issue_ready   = 1'b0;
    bus.write_address = 5'd0;
    bus.write_value   = 32'd0;
    bus.hazard_1      = 1'b0;
    bus.hazard_2      = 1'b0;
    if (!reset) begin
      bus.alu_ready     = alu_grant;
      bus.mem_ready     = mem_grant;
      bus.issue_ready   = bus.issue_valid && issue_ok;
      bus.write_address = wr_addr;
      bus.write_value   = wr_value;
      bus.hazard_1      = (bus.read_address_1 != 5'd0) && pend_full[bus.read_address_1];
      bus.hazard_2      = (bus.read_address_2 != 5'd0) && pend_full[bus.read_address_2];
    end
  end

  // State register: FSM, starvation counter and scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= 4'd0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for the register-file write scheduler.
module tb_regfile_write_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] rf [32];

  regfile_write_scheduler_if bus ();

  regfile_write_scheduler #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed by the write port
  always @(posedge clk) begin
    if (!reset && bus.write_address != 5'd0) rf[bus.write_address] <= bus.write_value;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_value = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_value = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.read_address_1 = 0; bus.read_address_2 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_value = 32'h11;
    bus.mem_valid = 1; bus.mem_rd = 5'd4; bus.mem_value = 32'h22;
    bus.issue_valid = 1; bus.issue_rd = 5'd6;
    bus.read_address_1 = 5'd6; bus.read_address_2 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      #1;
      $display("reset cycle %0d: ar=%b mr=%b ir=%b wa=%0d", i, bus.alu_ready, bus.mem_ready, bus.issue_ready, bus.write_address);
      checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b exp 0", bus.alu_ready); end
      checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b exp 0", bus.mem_ready); end
      checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %b exp 0", bus.issue_ready); end
      checks++; if (bus.write_address !== 5'd0) begin errors++; $display("FAIL reset_write_address: got %0d exp 0", bus.write_address); end
      checks++; if (bus.write_value !== 32'd0) begin errors++; $display("FAIL reset_write_value: got %h exp 0", bus.write_value); end
      checks++; if (bus.hazard_1 !== 1'b0 || bus.hazard_2 !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b%b exp 00", bus.hazard_1, bus.hazard_2); end
      step();
    end
    reset = 0;
    idle();
    bus.read_address_1 = 5'd6; bus.read_address_2 = 5'd4;
    bus.mem_valid = 1; bus.mem_rd = 5'd4; bus.mem_value = 32'h22;
    #1;
    $display("post-reset: h1=%b h2=%b mr=%b wa=%0d", bus.hazard_1, bus.hazard_2, bus.mem_ready, bus.write_address);
    checks++; if (bus.hazard_1 !== 1'b0 || bus.hazard_2 !== 1'b0) begin errors++; $display("FAIL post_reset_pending: got %b%b exp 00", bus.hazard_1, bus.hazard_2); end
    checks++; if (bus.mem_ready !== 1'b1 || bus.write_address !== 5'd4) begin errors++; $display("FAIL post_reset_mem: got mr=%b wa=%0d exp mr=1 wa=4", bus.mem_ready, bus.write_address); end
    step();
    idle();
  endtask

  task automatic test_alu_write();
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_value = 32'hDEADBEEF;
    #1;
    $display("alu write: ar=%b mr=%b wa=%0d wv=%h", bus.alu_ready, bus.mem_ready, bus.write_address, bus.write_value);
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL alu_grant: got ar=%b mr=%b exp ar=1 mr=0", bus.alu_ready, bus.mem_ready); end
    checks++; if (bus.write_address !== 5'd5 || bus.write_value !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write: got %0d/%h exp 5/deadbeef", bus.write_address, bus.write_value); end
    step();
    idle();
    #1;
    $display("rf[5]=%h", rf[5]);
    checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_r5: got %h exp deadbeef", rf[5]); end
    checks++; if (bus.write_address !== 5'd0) begin errors++; $display("FAIL idle_write_address: got %0d exp 0", bus.write_address); end
    step();
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_value = 32'hA1;
    bus.mem_valid = 1; bus.mem_rd = 5'd2; bus.mem_value = 32'hB2;
    for (int i = 1; i <= 4; i++) begin
      #1;
      $display("starve cycle %0d: ar=%b mr=%b wa=%0d", i, bus.alu_ready, bus.mem_ready, bus.write_address);
      checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0 || bus.write_address !== 5'd1) begin errors++; $display("FAIL starve_deny_%0d: got ar=%b mr=%b wa=%0d exp ar=1 mr=0 wa=1", i, bus.alu_ready, bus.mem_ready, bus.write_address); end
      step();
    end
    #1;
    $display("starve cycle 5: ar=%b mr=%b wa=%0d wv=%h", bus.alu_ready, bus.mem_ready, bus.write_address, bus.write_value);
    checks++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL force_grant: got ar=%b mr=%b exp ar=0 mr=1", bus.alu_ready, bus.mem_ready); end
    checks++; if (bus.write_address !== 5'd2 || bus.write_value !== 32'hB2) begin errors++; $display("FAIL force_write: got %0d/%h exp 2/b2", bus.write_address, bus.write_value); end
    step();
    #1;
    $display("starve cycle 6: ar=%b mr=%b", bus.alu_ready, bus.mem_ready);
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL after_force: got ar=%b mr=%b exp ar=1 mr=0", bus.alu_ready, bus.mem_ready); end
    step();
    idle();
    bus.mem_valid = 1; bus.mem_rd = 5'd2; bus.mem_value = 32'hB2;
    step();
    idle();
  endtask

  task automatic test_force_no_valid();
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_value = 32'hC1;
    bus.mem_valid = 1; bus.mem_rd = 5'd8; bus.mem_value = 32'hC8;
    for (int i = 0; i < 4; i++) step();
    bus.mem_valid = 0;
    #1;
    $display("force w/o mem: ar=%b mr=%b wa=%0d", bus.alu_ready, bus.mem_ready, bus.write_address);
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0 || bus.write_address !== 5'd1) begin errors++; $display("FAIL force_no_valid: got ar=%b mr=%b wa=%0d exp ar=1 mr=0 wa=1", bus.alu_ready, bus.mem_ready, bus.write_address); end
    step();
    bus.mem_valid = 1;
    #1;
    $display("back to normal: ar=%b mr=%b", bus.alu_ready, bus.mem_ready);
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL force_exit_normal: got ar=%b mr=%b exp ar=1 mr=0", bus.alu_ready, bus.mem_ready); end
    step();
    idle();
    bus.mem_valid = 1; bus.mem_rd = 5'd8; bus.mem_value = 32'hC8;
    step();
    idle();
  endtask

  task automatic test_hazard();
    bus.issue_valid = 1; bus.issue_rd = 5'd7; bus.read_address_1 = 5'd7;
    #1;
    $display("issue rd7: ir=%b h1=%b", bus.issue_ready, bus.hazard_1);
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_rd7: got %b exp 1", bus.issue_ready); end
    checks++; if (bus.hazard_1 !== 1'b0) begin errors++; $display("FAIL hazard_same_cycle: got %b exp 0", bus.hazard_1); end
    step();
    idle();
    bus.read_address_1 = 5'd7; bus.read_address_2 = 5'd7;
    for (int i = 0; i < 2; i++) begin
      #1;
      $display("pending rd7 cycle %0d: h1=%b h2=%b", i, bus.hazard_1, bus.hazard_2);
      checks++; if (bus.hazard_1 !== 1'b1 || bus.hazard_2 !== 1'b1) begin errors++; $display("FAIL hazard_pending_%0d: got %b%b exp 11", i, bus.hazard_1, bus.hazard_2); end
      step();
    end
    bus.mem_valid = 1; bus.mem_rd = 5'd7; bus.mem_value = 32'h77;
    #1;
    $display("mem rd7 writeback: mr=%b h1=%b", bus.mem_ready, bus.hazard_1);
    checks++; if (bus.mem_ready !== 1'b1 || bus.hazard_1 !== 1'b1) begin errors++; $display("FAIL hazard_during_clear: got mr=%b h1=%b exp mr=1 h1=1", bus.mem_ready, bus.hazard_1); end
    step();
    bus.mem_valid = 0;
    #1;
    $display("after rd7 writeback: h1=%b h2=%b", bus.hazard_1, bus.hazard_2);
    checks++; if (bus.hazard_1 !== 1'b0 || bus.hazard_2 !== 1'b0) begin errors++; $display("FAIL hazard_cleared: got %b%b exp 00", bus.hazard_1, bus.hazard_2); end
    step();
    idle();
  endtask

  task automatic test_issue_waw();
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    step();
    #1;
    $display("reissue rd9: ir=%b", bus.issue_ready);
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_block: got %b exp 0", bus.issue_ready); end
    step();
    bus.mem_valid = 1; bus.mem_rd = 5'd9; bus.mem_value = 32'h99;
    #1;
    $display("reissue rd9 with mem rd9: ir=%b mr=%b", bus.issue_ready, bus.mem_ready);
    checks++; if (bus.issue_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL waw_same_cycle: got ir=%b mr=%b exp ir=1 mr=1", bus.issue_ready, bus.mem_ready); end
    step();
    idle();
    bus.read_address_1 = 5'd9;
    #1;
    $display("rd9 after set+clear: h1=%b", bus.hazard_1);
    checks++; if (bus.hazard_1 !== 1'b1) begin errors++; $display("FAIL set_wins: got %b exp 1", bus.hazard_1); end
    bus.mem_valid = 1; bus.mem_rd = 5'd9;
    step();
    bus.mem_valid = 0;
    #1;
    checks++; if (bus.hazard_1 !== 1'b0) begin errors++; $display("FAIL rd9_final_clear: got %b exp 0", bus.hazard_1); end
    step();
    idle();
  endtask

  task automatic test_zero_rd();
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_value = 32'h5A;
    #1;
    $display("alu rd0: ar=%b wa=%0d", bus.alu_ready, bus.write_address);
    checks++; if (bus.alu_ready !== 1'b1 || bus.write_address !== 5'd0) begin errors++; $display("FAIL alu_rd0: got ar=%b wa=%0d exp ar=1 wa=0", bus.alu_ready, bus.write_address); end
    step();
    idle();
    bus.issue_valid = 1; bus.issue_rd = 5'd3;
    step();
    idle();
    bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_value = 32'h5B;
    bus.issue_valid = 1; bus.issue_rd = 5'd0;
    #1;
    $display("mem rd0 + issue rd0: mr=%b ir=%b wa=%0d", bus.mem_ready, bus.issue_ready, bus.write_address);
    checks++; if (bus.mem_ready !== 1'b1 || bus.write_address !== 5'd0) begin errors++; $display("FAIL mem_rd0: got mr=%b wa=%0d exp mr=1 wa=0", bus.mem_ready, bus.write_address); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL issue_rd0: got %b exp 1", bus.issue_ready); end
    step();
    idle();
    bus.read_address_1 = 5'd0; bus.read_address_2 = 5'd3;
    #1;
    $display("read rd0/rd3: h1=%b h2=%b", bus.hazard_1, bus.hazard_2);
    checks++; if (bus.hazard_1 !== 1'b0) begin errors++; $display("FAIL hazard_rd0: got %b exp 0", bus.hazard_1); end
    checks++; if (bus.hazard_2 !== 1'b1) begin errors++; $display("FAIL rd3_kept: got %b exp 1", bus.hazard_2); end
    bus.mem_valid = 1; bus.mem_rd = 5'd3;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1; bus.issue_rd = 5'd11;
    step();
    idle();
    bus.read_address_1 = 5'd11;
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_value = 32'hE1;
    bus.mem_valid = 1; bus.mem_rd = 5'd12; bus.mem_value = 32'hE2;
    #1;
    checks++; if (bus.hazard_1 !== 1'b1) begin errors++; $display("FAIL rd11_pending: got %b exp 1", bus.hazard_1); end
    for (int i = 0; i < 4; i++) step();
    reset = 1;
    #1;
    $display("reset in force: ar=%b mr=%b h1=%b", bus.alu_ready, bus.mem_ready, bus.hazard_1);
    checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0 || bus.hazard_1 !== 1'b0) begin errors++; $display("FAIL reset_mid: got ar=%b mr=%b h1=%b exp 000", bus.alu_ready, bus.mem_ready, bus.hazard_1); end
    step();
    reset = 0;
    #1;
    $display("after mid reset: ar=%b mr=%b h1=%b", bus.alu_ready, bus.mem_ready, bus.hazard_1);
    checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_to_normal: got ar=%b mr=%b exp ar=1 mr=0", bus.alu_ready, bus.mem_ready); end
    checks++; if (bus.hazard_1 !== 1'b0) begin errors++; $display("FAIL reset_clears_pending: got %b exp 0", bus.hazard_1); end
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1;
    test_reset();
    test_alu_write();
    test_starvation();
    test_force_no_valid();
    test_hazard();
    test_issue_waw();
    test_zero_rd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
